// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle controller: opcodes, state encoding,
// ALU operation codes and the PC / write-data source selects.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [1:0] WD_MEM = 2'd0;
  localparam logic [1:0] WD_ALU = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath signal bundle. The controller drives the control
// outputs (master); the datapath/memory side supplies instruction fields and
// status (slave).
interface multicycle_control_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       alu_zero;
  logic       mem_ready;

  logic       pc_write;
  logic       ir_write;
  logic [1:0] OrigPC;
  logic [1:0] OrigWriteData;
  logic [3:0] ALUControl;
  logic       OrigULA;
  logic       MemRead;
  logic       MemWrite;
  logic       RegWrite;
  logic       illegal;
  logic [2:0] state;

  modport master (
    input  opcode, funct3, funct7_5, alu_zero, mem_ready,
    output pc_write, ir_write, OrigPC, OrigWriteData, ALUControl, OrigULA,
           MemRead, MemWrite, RegWrite, illegal, state
  );

  modport slave (
    output opcode, funct3, funct7_5, alu_zero, mem_ready,
    input  pc_write, ir_write, OrigPC, OrigWriteData, ALUControl, OrigULA,
           MemRead, MemWrite, RegWrite, illegal, state
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation decode from opcode and funct fields. Purely combinational.
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] alu_control_o
);

  // Map instruction class and funct3 onto an ALU operation
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    alu_control_o = ALU_ADD;
    case (opcode_i)
      OP_R, OP_I: begin
        case (funct3_i)
          3'b000:  alu_control_o = (opcode_i == OP_R && funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_control_o = ALU_AND;
          3'b110:  alu_control_o = ALU_OR;
          3'b010:  alu_control_o = ALU_SLT;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      OP_BRANCH: alu_control_o = ALU_SUB;
      default:   alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style main controller: FETCH/DECODE/EXEC/MEM/WB.
// Optional feature macro ECALL_HALT_EN: opcode 1110011 enters a sticky HALT
// state; without it that opcode is reported as illegal.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input logic                 clock,
  input logic                 reset,
  multicycle_control_if.master bus
);

  state_e     state_q, state_d;
  logic [3:0] alu_ctrl;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write, illegal;
  logic [1:0] orig_pc, orig_wd;
  logic       orig_ula;

  alu_decoder u_alu_decoder (
    .opcode_i      (bus.opcode),
    .funct3_i      (bus.funct3),
    .funct7_5_i    (bus.funct7_5),
    .alu_control_o (alu_ctrl)
  );

  // State register, forced to FETCH asynchronously by reset
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of evaluation order.
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and control decode for the current state
  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    orig_pc   = PC_PLUS4;
    orig_wd   = WD_ALU;
    orig_ula  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH: state_d = S_EXEC;
          OP_JAL: state_d = S_WB;
`ifdef ECALL_HALT_EN
          OP_SYSTEM: state_d = S_HALT;
`endif
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        orig_ula = (bus.opcode == OP_I) || (bus.opcode == OP_LOAD) ||
                   (bus.opcode == OP_STORE);
        case (bus.opcode)
          OP_R, OP_I:         state_d = S_WB;
          OP_LOAD, OP_STORE:  state_d = S_MEM;
          OP_BRANCH: begin
            orig_pc = PC_BRANCH;
            if (bus.funct3 == F3_BEQ)      pc_write = bus.alu_zero;
            else if (bus.funct3 == F3_BNE) pc_write = ~bus.alu_zero;
            state_d = S_FETCH;
          end
          default:            state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_read  = (bus.opcode == OP_LOAD);
        mem_write = (bus.opcode == OP_STORE);
        if (bus.mem_ready) state_d = (bus.opcode == OP_LOAD) ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_write = 1'b1;
        if (bus.opcode == OP_LOAD) begin
          orig_wd = WD_MEM;
        end else if (bus.opcode == OP_JAL) begin
          orig_wd  = WD_PC4;
          pc_write = 1'b1;
          orig_pc  = PC_JUMP;
        end
        state_d = S_FETCH;
      end
`ifdef ECALL_HALT_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: enables are gated by reset directly so an in-flight access is
  // dropped the moment reset rises, without waiting for a clock edge.
  assign bus.pc_write      = pc_write  & ~reset;
  assign bus.ir_write      = ir_write  & ~reset;
  assign bus.MemRead       = mem_read  & ~reset;
  assign bus.MemWrite      = mem_write & ~reset;
  assign bus.RegWrite      = reg_write & ~reset;
  assign bus.illegal       = illegal   & ~reset;
  assign bus.OrigPC        = orig_pc;
  assign bus.OrigWriteData = orig_wd;
  assign bus.OrigULA       = orig_ula;
  assign bus.ALUControl    = alu_ctrl;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each instruction is expanded by
// a per-instruction reference model into the expected cycle-by-cycle trace
// (state, enables, selects), which is then replayed against the DUT.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  multicycle_control_if bus ();

  multicycle_control dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected behaviour of one clock cycle
  typedef struct {
    int         st;
    bit         mr;       // mem_ready to drive this cycle
    bit [5:0]   en;       // {pc_write, ir_write, MemRead, MemWrite, RegWrite, illegal}
    bit [1:0]   opc;      // OrigPC, checked when pc_write expected
    bit [1:0]   owd;      // OrigWriteData, checked when RegWrite expected
    bit         chk_alu;
    bit [3:0]   aluc;
    bit         oula;
  } exp_t;

  exp_t q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(int st, bit mr, bit [5:0] en);
    exp_t e;
    e.st = st; e.mr = mr; e.en = en;
    e.opc = 2'd0; e.owd = 2'd0; e.chk_alu = 1'b0; e.aluc = 4'd0; e.oula = 1'b0;
    return e;
  endfunction

  // ALU operation required for an instruction in EXEC
  function automatic bit [3:0] alu_ref(bit [6:0] op, bit [2:0] f3, bit f7);
    if (op == OP_LOAD || op == OP_STORE) return 4'b0010;
    if (op == OP_BRANCH) return 4'b0110;
    case (f3)
      3'b000:  return (op == OP_R && f7) ? 4'b0110 : 4'b0010;
      3'b111:  return 4'b0000;
      3'b110:  return 4'b0001;
      default: return 4'b0111;  // 010, the only other funct3 generated
    endcase
  endfunction

  function automatic bit is_legal(bit [6:0] op);
    return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL};
  endfunction

  // Reference model: expand one instruction into its expected trace
  task automatic build(input bit [6:0] op, input bit [2:0] f3, input bit f7,
                       input bit z, input int fw, input int mw);
    exp_t e;
    for (int i = 0; i < fw; i++) q.push_back(mk(0, 1'b0, 6'b001000));
    q.push_back(mk(0, 1'b1, 6'b111000));
`ifdef ECALL_HALT_EN
    if (op == OP_SYSTEM) begin
      q.push_back(mk(1, 1'($urandom), 6'b000000));
      for (int i = 0; i < 10; i++) q.push_back(mk(5, 1'($urandom), 6'b000000));
      return;
    end
`endif
    if (!is_legal(op)) begin
      q.push_back(mk(1, 1'($urandom), 6'b000001));
      return;
    end
    q.push_back(mk(1, 1'($urandom), 6'b000000));
    if (op == OP_JAL) begin
      e = mk(4, 1'($urandom), 6'b100010); e.opc = 2'd2; e.owd = 2'd2;
      q.push_back(e);
      return;
    end
    e = mk(2, 1'($urandom), 6'b000000);
    e.chk_alu = 1'b1;
    e.aluc = alu_ref(op, f3, f7);
    e.oula = (op != OP_R && op != OP_BRANCH);
    if (op == OP_BRANCH) begin
      e.en[5] = (f3 == 3'b000) ? z : !z;
      e.opc = 2'd1;
    end
    q.push_back(e);
    if (op == OP_LOAD || op == OP_STORE) begin
      for (int i = 0; i < mw; i++)
        q.push_back(mk(3, 1'b0, (op == OP_LOAD) ? 6'b001000 : 6'b000100));
      q.push_back(mk(3, 1'b1, (op == OP_LOAD) ? 6'b001000 : 6'b000100));
    end
    if (op == OP_R || op == OP_I || op == OP_LOAD) begin
      e = mk(4, 1'($urandom), 6'b000010);
      e.owd = (op == OP_LOAD) ? 2'd0 : 2'd1;
      q.push_back(e);
    end
  endtask

  // Replay one expected cycle: drive, sample at negedge, advance past posedge
  task automatic step();
    exp_t e;
    e = q.pop_front();
    bus.mem_ready = e.mr;
    @(negedge clock);
    check("state", 32'(bus.state), 32'(e.st));
    check("enables", 32'({bus.pc_write, bus.ir_write, bus.MemRead, bus.MemWrite,
                          bus.RegWrite, bus.illegal}), 32'(e.en));
    check("rd_wr_excl", 32'(bus.MemRead & bus.MemWrite), 32'd0);
    if (e.en[5]) check("OrigPC", 32'(bus.OrigPC), 32'(e.opc));
    if (e.en[1]) check("OrigWriteData", 32'(bus.OrigWriteData), 32'(e.owd));
    if (e.chk_alu) begin
      check("ALUControl", 32'(bus.ALUControl), 32'(e.aluc));
      check("OrigULA", 32'(bus.OrigULA), 32'(e.oula));
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run(input bit [6:0] op, input bit [2:0] f3, input bit f7,
                     input bit z, input int fw, input int mw);
    bus.opcode = op; bus.funct3 = f3; bus.funct7_5 = f7; bus.alu_zero = z;
    build(op, f3, f7, z, fw, mw);
    while (q.size() > 0) step();
  endtask

  initial begin
    bit [6:0] op;
    bit [2:0] f3;
    bus.opcode = 7'd0; bus.funct3 = 3'd0; bus.funct7_5 = 1'b0;
    bus.alu_zero = 1'b0; bus.mem_ready = 1'b1;

    // Reset state: FETCH with all enables idle even with mem_ready high
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_enables", 32'({bus.pc_write, bus.ir_write, bus.MemRead, bus.MemWrite,
                              bus.RegWrite, bus.illegal}), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Directed scenarios
    run(OP_R, 3'b000, 1'b1, 1'b0, 0, 0);        // SUB, 4 cycles
    run(OP_LOAD, 3'b010, 1'b0, 1'b0, 0, 2);     // LOAD with 2 wait cycles
    run(OP_BRANCH, F3_BEQ, 1'b0, 1'b1, 0, 0);   // BEQ taken
    run(OP_BRANCH, F3_BEQ, 1'b0, 1'b0, 0, 0);   // BEQ not taken
    run(OP_BRANCH, F3_BNE, 1'b0, 1'b0, 1, 0);   // BNE taken
    run(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0);  // illegal
    run(OP_JAL, 3'b000, 1'b0, 1'b0, 2, 0);

    // Reset in the middle of a stalled STORE
    bus.opcode = OP_STORE; bus.funct3 = 3'b010; bus.funct7_5 = 1'b0;
    build(OP_STORE, 3'b010, 1'b0, 1'b0, 0, 5);
    repeat (4) step();
    q.delete();
    bus.mem_ready = 1'b0;
    #1;
    check("store_wait_memwrite", 32'(bus.MemWrite), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_state", 32'(bus.state), 32'd0);
    check("abort_enables", 32'({bus.pc_write, bus.ir_write, bus.MemWrite,
                                bus.RegWrite, bus.illegal}), 32'd0);
    bus.mem_ready = 1'b1;
    @(posedge clock); #1;
    check("abort_hold_state", 32'(bus.state), 32'd0);
    check("abort_hold_pcw", 32'(bus.pc_write), 32'd0);
    reset = 1'b0;
    run(OP_I, 3'b110, 1'b1, 1'b0, 0, 0);

    // ECALL: HALT when the feature is built in, illegal otherwise
    run(OP_SYSTEM, 3'b000, 1'b0, 1'b0, 0, 0);
`ifdef ECALL_HALT_EN
    reset = 1'b1;
    #1;
    check("halt_reset_state", 32'(bus.state), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
`endif

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        0: op = OP_R;
        1: op = OP_I;
        2: op = OP_LOAD;
        3: op = OP_STORE;
        4: op = OP_BRANCH;
        5: op = OP_JAL;
        default: begin
          op = 7'($urandom);
          while (is_legal(op) || op == OP_SYSTEM) op = 7'($urandom);
        end
      endcase
      if (op == OP_BRANCH) f3 = 3'($urandom_range(0, 1));
      else case ($urandom_range(0, 3))
        0: f3 = 3'b000;
        1: f3 = 3'b111;
        2: f3 = 3'b110;
        default: f3 = 3'b010;
      endcase
      run(op, f3, 1'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
